// File: rtl/seg_scan_ctrl_if.sv
// Scan controller bus: enable and digit mask in, digit select, anodes and frame marker out.
// No clock here; the controller samples everything on clk at the top level.
interface seg_scan_ctrl_if;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [7:0] an;
  logic       frame_done;

  modport master (
    output en,
    output digit_mask,
    input  sel,
    input  an,
    input  frame_done
  );

  modport slave (
    input  en,
    input  digit_mask,
    output sel,
    output an,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: BLANK/ON phases per digit, active-low anodes, frame pulse.
// All outputs registered from next-state decode; en low darkens the display and freezes sel.
module seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int NUM_DIGITS   = 4
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(CLK_DIV - 1);
  localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    sel;
  logic [7:0]    an;
  logic          frame_done;
  logic          mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      sel        <= 3'd0;
      an         <= 8'hFF;
      frame_done <= 1'b0;
      mask_q     <= 1'b0;
    end else if (!bus.en) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      an         <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt    <= '0;
            state  <= ST_ON;
            mask_q <= bus.digit_mask[sel];
            // anodes go low in the very first ON cycle, so decode from the mask being latched
            an     <= bus.digit_mask[sel] ? ~(8'd1 << sel) : 8'hFF;
          end else begin
            cnt <= cnt + 1'b1;
            an  <= 8'hFF;
          end
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            cnt        <= '0;
            state      <= ST_BLANK;
            an         <= 8'hFF;
            sel        <= (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
            frame_done <= (sel == SEL_LAST);
          end else begin
            cnt <= cnt + 1'b1;
            an  <= mask_q ? ~(8'd1 << sel) : 8'hFF;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
          an    <= 8'hFF;
        end
      endcase
    end
  end

  assign bus.sel        = sel;
  assign bus.an         = an;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a slot-position reference model.
// Runs a 4-digit and a 1-digit build side by side from the same stimulus.
module tb_seg_scan_ctrl;

  localparam int C = 4;
  localparam int B = 2;

  logic clk;
  logic reset;

  seg_scan_ctrl_if bus4 ();
  seg_scan_ctrl_if bus1 ();

  seg_scan_ctrl #(.CLK_DIV(C), .BLANK_CYCLES(B), .NUM_DIGITS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  seg_scan_ctrl #(.CLK_DIV(C), .BLANK_CYCLES(B), .NUM_DIGITS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnum   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cnum, obs, exp);
    end
  endtask

  // Model: each digit owns a slot of B+C cycles; the first B are dark, the rest lit if masked in.
  typedef struct {
    int d;
    int p;
    bit m;
    bit fd;
  } mdl_t;

  mdl_t s4, s1;

  function automatic mdl_t mstep(mdl_t s, bit rst, bit en, logic [7:0] mask, int n);
    mdl_t r = s;
    if (rst) begin
      r.d = 0; r.p = 0; r.m = 0; r.fd = 0;
    end else if (!en) begin
      r.p = 0; r.fd = 0;
    end else begin
      r.fd = 0;
      if (s.p == B - 1) r.m = mask[s.d];
      if (s.p == B + C - 1) begin
        r.p  = 0;
        r.fd = (s.d == n - 1);
        r.d  = (s.d + 1) % n;
      end else begin
        r.p = s.p + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] m_an(mdl_t s);
    logic [7:0] one;
    if (s.p < B || !s.m) return 8'hFF;
    one = 8'd1 << s.d;
    return ~one;
  endfunction

  task automatic cyc(input bit r, input bit e, input logic [7:0] mk);
    reset           = r;
    bus4.en         = e;
    bus1.en         = e;
    bus4.digit_mask = mk;
    bus1.digit_mask = mk;
    @(posedge clk);
    s4 = mstep(s4, r, e, mk, 4);
    s1 = mstep(s1, r, e, mk, 1);
    cnum = r ? 0 : cnum + 1;
    #1;
    chk("sel4", 32'(bus4.sel), 32'(s4.d));
    chk("an4",  32'(bus4.an),  32'(m_an(s4)));
    chk("fd4",  32'(bus4.frame_done), 32'(s4.fd));
    chk("sel1", 32'(bus1.sel), 32'(s1.d));
    chk("an1",  32'(bus1.an),  32'(m_an(s1)));
    chk("fd1",  32'(bus1.frame_done), 32'(s1.fd));
  endtask

  task automatic do_reset();
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h0F);
    chk("rst_sel", 32'(bus4.sel), 32'd0);
    chk("rst_an",  32'(bus4.an),  32'hFF);
    chk("rst_fd",  32'(bus4.frame_done), 32'd0);
  endtask

  initial begin
    s4 = '{0, 0, 0, 0};
    s1 = '{0, 0, 0, 0};
    do_reset();

    // Basic scan: frame pulse only every 24 cycles, 1-digit build every 6
    for (int i = 1; i <= 80; i++) begin
      cyc(0, 1, 8'h0F);
      chk("fd4_period", 32'(bus4.frame_done), 32'(cnum % 24 == 0));
      chk("fd1_period", 32'(bus1.frame_done), 32'(cnum % 6 == 0));
      if (cnum == 3)  chk("an_d0",  32'(bus4.an), 32'hFE);
      if (cnum == 9)  chk("an_d1",  32'(bus4.an), 32'hFD);
      if (cnum == 15) chk("an_d2",  32'(bus4.an), 32'hFB);
      if (cnum == 21) chk("an_d3",  32'(bus4.an), 32'hF7);
      if (cnum == 7)  chk("sel_d1", 32'(bus4.sel), 32'd1);
    end

    // Mask: digits 0 and 2 only, then widen mid-ON of digit 1
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 1, (cnum >= 9) ? 8'h0F : 8'h05);
      if (cnum == 10) chk("mask_dark_d1", 32'(bus4.an), 32'hFF);
      if (cnum == 33) chk("mask_lit_d1",  32'(bus4.an), 32'hFD);
    end

    // Enable drop during digit 1 ON, then restore
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      cyc(0, !(cnum >= 9 && cnum < 21), 8'h0F);
      if (cnum == 12) chk("en_dark", 32'(bus4.an), 32'hFF);
      if (cnum == 12) chk("en_sel",  32'(bus4.sel), 32'd1);
      if (cnum == 23) chk("en_relit", 32'(bus4.an), 32'hFD);
    end

    // Reset during digit 2 ON, then basic scan again
    do_reset();
    for (int i = 1; i <= 14; i++) cyc(0, 1, 8'h0F);
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 1, 8'h0F);
      chk("rst_fd_period", 32'(bus4.frame_done), 32'(cnum % 24 == 0));
    end

    // Random soak
    begin
      logic [7:0] mk;
      mk = 8'h0F;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) mk = 8'($urandom);
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0, mk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
